fifo_skew_scheduler: RTL and testbench
======================================

Name: fifo_skew_scheduler

Overview:
- Read-side scheduler for a bank of ROWS fifo_mem instances that feed the rows of the systolic array.
- On start, it issues a diagonally skewed read burst: row i begins i cycles after row 0, so operands meet the correct PEs on the correct cycle.
- It stalls the whole wavefront when any FIFO that must be read is empty, and raises a done pulse when the burst completes.

Parameters:
- ROWS, 4: number of FIFO/array rows scheduled.
- CNT_WIDTH, 8: width of the burst length and the step counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- start  input  1  one-cycle burst request; sampled only in IDLE.
- length  input  CNT_WIDTH  words per row; latched when start is accepted.
- fifo_empty  input  ROWS  per-row fifo_mem empty flags (bit i = row i).
- fifo_read  output  ROWS  per-row fifo_mem read strobes.
- row_valid  output  ROWS  registered copy of fifo_read; marks fifo_mem data_out valid, one cycle after the read.
- stall  output  1  high in a RUN cycle where the wavefront is frozen.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the burst ends.

Behaviour:
- Reset (asynchronous, active low):
  - state=IDLE, step counter t=0, latched length L=0.
  - fifo_read=0, row_valid=0, stall=0, busy=0, done=0.
  - Reset asserted mid-burst aborts at once: no done pulse, outputs go to reset values asynchronously.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and length>0: latch L=length, t=0, go to RUN.
  - start=1 and length=0: go to DONE; no reads are issued.
  - start=0: remain in IDLE.
- RUN:
  - Total steps T = L+ROWS-1, computed at CNT_WIDTH+1 bits so it cannot overflow.
  - Row i is active at step t when i <= t < i+L (unsigned compare at CNT_WIDTH+1 bits).
  - need[i] = row i active at step t.
  - stall = OR over i of (need[i] AND fifo_empty[i]).
  - stall=0: fifo_read = need; t increments.
  - stall=1: fifo_read = 0 for all rows and t holds. The wavefront never tears; skew between rows is preserved.
  - fifo_read and stall are combinational from t, L and fifo_empty.
- RUN exit: on the non-stalled cycle with t = T-1, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE.
- start while busy: ignored; length is not re-latched.
- row_valid: registered from fifo_read every cycle; cleared by reset. The last row_valid may coincide with the DONE cycle.
- Guarantees:
  - No read strobe is ever driven to an empty FIFO, so fifo_mem underflow is never provoked.
  - Each row is read exactly L times per burst.
- Burst latency with no stalls:
  - start in cycle 0; first fifo_read[0] in cycle 1; last fifo_read[ROWS-1] in cycle L+ROWS-1.
  - done in cycle L+ROWS.

Test Plan:
- Basic burst: ROWS=4, all FIFOs non-empty, start with length=3 -> fifo_read per cycle from cycle 1 = 0001, 0011, 0111, 1110, 1100, 1000; done in cycle 7; row_valid = fifo_read delayed one cycle.
- Stall: length=3, fifo_empty[2] held high during step t=2 for 2 cycles -> fifo_read=0000 and stall=1 for those 2 cycles; schedule then resumes 0111, 1110, 1100, 1000; done 2 cycles later than the basic burst.
- Inactive row empty: length=3, fifo_empty[3]=1 during t=0..2 -> no stall, since row 3 is not yet active; pattern identical to the basic burst.
- Zero length: start with length=0 -> fifo_read stays 0000; busy and done high for one cycle; back in IDLE next cycle.
- start while busy: pulse start with length=9 during a length=3 burst -> ignored; exactly 3 reads per row; single done pulse.
- Reset mid-burst: drop reset_n at t=2 -> fifo_read, row_valid, busy and stall go to 0 immediately; no done pulse; a fresh start after release yields a clean burst.

Source files
------------

// File: rtl/fifo_skew_scheduler_if.sv
// Handshake/bus bundle between the skewed read scheduler and its controller/FIFO bank.
interface fifo_skew_scheduler_if #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 start;
    logic [CNT_WIDTH-1:0] length;
    logic [ROWS-1:0]      fifo_empty;
    logic [ROWS-1:0]      fifo_read;
    logic [ROWS-1:0]      row_valid;
    logic                 stall;
    logic                 busy;
    logic                 done;

    modport master (
        output start, length, fifo_empty,
        input  fifo_read, row_valid, stall, busy, done
    );

    modport slave (
        input  start, length, fifo_empty,
        output fifo_read, row_valid, stall, busy, done
    );
endinterface

// File: rtl/fifo_skew_scheduler.sv
// Read-side scheduler: issues a diagonally skewed read burst across ROWS FIFOs,
// freezing the whole wavefront whenever any row that must be read is empty.
module fifo_skew_scheduler #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fifo_skew_scheduler_if.slave  bus
);
    localparam int unsigned TW = CNT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TW-1:0]        t;
    logic [CNT_WIDTH-1:0] len;
    logic [TW-1:0]        t_last;
    logic [ROWS-1:0]      need_c;
    logic                 hold_c;
    logic [ROWS-1:0]      read_c;
    logic                 stall_c;
    logic                 busy_c;
    logic                 done_c;
    logic [ROWS-1:0]      row_valid_q;

    // Last step index is L+ROWS-2; kept one bit wider than the length so it never wraps.
    assign t_last = {1'b0, len} + TW'(ROWS - 1) - TW'(1);

    // Row i reads during steps i .. i+L-1.
    always_comb begin
        need_c = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            need_c[i] = (t >= TW'(i)) && (t < (TW'(i) + {1'b0, len}));
        end
    end

    assign hold_c = |(need_c & bus.fifo_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.length != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!hold_c && (t == t_last)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read_c  = '0;
        stall_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            RUN: begin
                stall_c = hold_c;
                read_c  = hold_c ? '0 : need_c;
                busy_c  = 1'b1;
            end
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Step counter and latched length; start is only honoured in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t   <= '0;
            len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && (bus.length != '0)) begin
                        len <= bus.length;
                        t   <= '0;
                    end
                end
                RUN: begin
                    if (!hold_c) begin
                        t <= t + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_valid_q <= '0;
        end else begin
            row_valid_q <= read_c;
        end
    end

    assign bus.fifo_read = read_c;
    assign bus.stall     = stall_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.row_valid = row_valid_q;

endmodule

// File: tb/tb_fifo_skew_scheduler.sv
// Bench for fifo_skew_scheduler: directed bursts plus randomized empties/starts against a wavefront model.
module tb_fifo_skew_scheduler;
    localparam int unsigned ROWS = 4;
    localparam int unsigned CW   = 8;
    localparam int IDLE_M = 0;
    localparam int RUN_M  = 1;
    localparam int DONE_M = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fifo_skew_scheduler_if #(.ROWS(ROWS), .CNT_WIDTH(CW)) bus ();

    fifo_skew_scheduler #(.ROWS(ROWS), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: wavefront step counts non-stalled cycles since start.
    int              m_mode = IDLE_M;
    int              m_step = 0;
    int              m_len  = 0;
    int              exp_reads = 0;
    logic [ROWS-1:0] m_prev = '0;
    int              rd_cnt [ROWS];

    logic [ROWS-1:0] obs_read;
    logic            obs_done;
    logic [ROWS-1:0] rd_log [32];
    logic [3:0]      pat_basic [6];
    logic [3:0]      pat_stall [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return #1 after the rising edge.
    task automatic step_cycle();
        logic [ROWS-1:0] need;
        logic [ROWS-1:0] er;
        logic es, eb, ed;
        @(negedge clk);
        need = '0; er = '0; es = 1'b0; eb = 1'b0; ed = 1'b0;
        if (m_mode == RUN_M) begin
            for (int i = 0; i < int'(ROWS); i++)
                if (m_step >= i && m_step < i + m_len) need[i] = 1'b1;
            es = |(need & bus.fifo_empty);
            er = es ? '0 : need;
            eb = 1'b1;
        end else if (m_mode == DONE_M) begin
            eb = 1'b1;
            ed = 1'b1;
        end
        check("fifo_read", 32'(bus.fifo_read), 32'(er));
        check("stall", 32'(bus.stall), 32'(es));
        check("busy", 32'(bus.busy), 32'(eb));
        check("done", 32'(bus.done), 32'(ed));
        check("row_valid", 32'(bus.row_valid), 32'(m_prev));
        check("read_of_empty", 32'(bus.fifo_read & bus.fifo_empty), 32'(0));
        obs_read = bus.fifo_read;
        obs_done = bus.done;
        for (int i = 0; i < int'(ROWS); i++)
            if (bus.fifo_read[i] === 1'b1) rd_cnt[i]++;
        if (ed) begin
            for (int i = 0; i < int'(ROWS); i++) check("row_read_count", 32'(rd_cnt[i]), 32'(exp_reads));
        end
        m_prev = er;
        case (m_mode)
            IDLE_M: if (bus.start) begin
                for (int i = 0; i < int'(ROWS); i++) rd_cnt[i] = 0;
                if (bus.length != '0) begin
                    m_mode = RUN_M; m_len = int'(bus.length); m_step = 0; exp_reads = m_len;
                end else begin
                    m_mode = DONE_M; exp_reads = 0;
                end
            end
            RUN_M: if (!es) begin
                if (m_step == m_len + int'(ROWS) - 2) m_mode = DONE_M;
                else m_step++;
            end
            default: m_mode = IDLE_M;
        endcase
        @(posedge clk);
        #1;
    endtask

    // kind: 0 clean, 1 row2 empty at t=2 for 2 cycles, 2 inactive row3 empty,
    //       3 start while busy, 4 random empties and starts.
    task automatic burst(input int len, input int kind, output int done_at, output int n_done);
        int k;
        done_at = -1; n_done = 0; k = 0;
        bus.start = 1'b1; bus.length = CW'(len); bus.fifo_empty = '0;
        step_cycle();
        rd_log[0] = obs_read;
        if (obs_done) begin done_at = 0; n_done++; end
        bus.start = 1'b0;
        while (m_mode != IDLE_M && k < 600) begin
            k++;
            bus.fifo_empty = '0;
            case (kind)
                1: if (k == 3 || k == 4) bus.fifo_empty[2] = 1'b1;
                2: if (k >= 1 && k <= 3) bus.fifo_empty[3] = 1'b1;
                3: begin
                    bus.start  = (k == 2);
                    bus.length = (k == 2) ? CW'(9) : CW'(len);
                end
                4: begin
                    bus.fifo_empty = ROWS'($urandom & $urandom);
                    bus.start      = ($urandom_range(0, 7) == 0);
                    bus.length     = CW'($urandom_range(0, 15));
                end
                default: ;
            endcase
            step_cycle();
            if (k < 32) rd_log[k] = obs_read;
            if (obs_done) begin done_at = k; n_done++; end
        end
        bus.start = 1'b0;
        bus.fifo_empty = '0;
        if (k >= 600) check("burst_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        int d, n, len;
        pat_basic = '{4'h1, 4'h3, 4'h7, 4'he, 4'hc, 4'h8};
        pat_stall = '{4'h1, 4'h3, 4'h0, 4'h0, 4'h7, 4'he, 4'hc, 4'h8};
        for (int i = 0; i < int'(ROWS); i++) rd_cnt[i] = 0;
        bus.start = 1'b0; bus.length = '0; bus.fifo_empty = '0;

        #1;
        check("rst_fifo_read", 32'(bus.fifo_read), 32'(0));
        check("rst_row_valid", 32'(bus.row_valid), 32'(0));
        check("rst_stall", 32'(bus.stall), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        step_cycle();

        burst(3, 0, d, n);
        check("basic_done_cycle", 32'(d), 32'(7));
        check("basic_done_count", 32'(n), 32'(1));
        for (int i = 0; i < 6; i++) check("basic_pattern", 32'(rd_log[i + 1]), 32'(pat_basic[i]));

        burst(3, 1, d, n);
        check("stall_done_cycle", 32'(d), 32'(9));
        for (int i = 0; i < 8; i++) check("stall_pattern", 32'(rd_log[i + 1]), 32'(pat_stall[i]));

        burst(3, 2, d, n);
        check("inactive_done_cycle", 32'(d), 32'(7));
        for (int i = 0; i < 6; i++) check("inactive_pattern", 32'(rd_log[i + 1]), 32'(pat_basic[i]));

        burst(0, 0, d, n);
        check("zero_done_cycle", 32'(d), 32'(1));
        check("zero_done_count", 32'(n), 32'(1));
        step_cycle();

        burst(3, 3, d, n);
        check("busy_start_done_cycle", 32'(d), 32'(7));
        check("busy_start_done_count", 32'(n), 32'(1));

        // Reset in the cycle where t=2: everything must drop without waiting for a clock.
        bus.start = 1'b1; bus.length = CW'(3);
        step_cycle();
        bus.start = 1'b0;
        step_cycle();
        step_cycle();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_fifo_read", 32'(bus.fifo_read), 32'(0));
        check("midrst_row_valid", 32'(bus.row_valid), 32'(0));
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_stall", 32'(bus.stall), 32'(0));
        check("midrst_done", 32'(bus.done), 32'(0));
        m_mode = IDLE_M; m_prev = '0;
        @(posedge clk); #1;
        check("midrst_held_done", 32'(bus.done), 32'(0));
        reset_n = 1'b1;
        step_cycle();
        burst(3, 0, d, n);
        check("post_rst_done_cycle", 32'(d), 32'(7));
        for (int i = 0; i < 6; i++) check("post_rst_pattern", 32'(rd_log[i + 1]), 32'(pat_basic[i]));

        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(1, 40));
            burst(len, 0, d, n);
            check("latency_done_cycle", 32'(d), 32'(len + int'(ROWS)));
        end

        for (int r = 0; r < 30; r++) begin
            len = int'($urandom_range(0, 12));
            burst(len, 4, d, n);
            check("rand_done_count", 32'(n), 32'(1));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
